pipe_ctrl: RTL and testbench

- Central pipeline controller for the 16-bit, 5-stage CPU (IF/ID/EX/MEM/WB, gr[0..7], flags cf/zf/nf).
- Owns the run state machine (start/enable/HALT) and load-use hazard stalls.
- Owns taken-branch/jump redirect and flush; maintains cycle and stall counters for debug.
- Sits beside the datapath; drives every pipeline-register write enable and flush.

---
 rtl/cpu_defs.sv | 74 +++++++
 rtl/hazard_detect.sv | 63 ++++++
 rtl/pipe_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcodes, instruction field slices, controller state.
// Imported by the pipeline controller and the hazard detector.
package cpu_defs;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_SLL   = 5'b00100;
  localparam logic [4:0] OP_SRL   = 5'b00101;
  localparam logic [4:0] OP_SLA   = 5'b00110;
  localparam logic [4:0] OP_SRA   = 5'b00111;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_SUB   = 5'b01010;
  localparam logic [4:0] OP_SUBI  = 5'b01011;
  localparam logic [4:0] OP_CMP   = 5'b01100;
  localparam logic [4:0] OP_AND   = 5'b01101;
  localparam logic [4:0] OP_OR    = 5'b01110;
  localparam logic [4:0] OP_XOR   = 5'b01111;
  localparam logic [4:0] OP_LDIH  = 5'b10000;
  localparam logic [4:0] OP_ADDC  = 5'b10001;
  localparam logic [4:0] OP_SUBC  = 5'b10010;
  localparam logic [4:0] OP_JUMP  = 5'b11000;
  localparam logic [4:0] OP_JMPR  = 5'b11001;
  localparam logic [4:0] OP_BZ    = 5'b11010;
  localparam logic [4:0] OP_BNZ   = 5'b11011;
  localparam logic [4:0] OP_BN    = 5'b11100;
  localparam logic [4:0] OP_BNN   = 5'b11101;
  localparam logic [4:0] OP_BC    = 5'b11110;
  localparam logic [4:0] OP_BNC   = 5'b11111;

  localparam int OP_HI = 15;
  localparam int OP_LO = 11;
  localparam int R1_HI = 10;
  localparam int R1_LO = 8;
  localparam int R2_HI = 6;
  localparam int R2_LO = 4;
  localparam int R3_HI = 2;
  localparam int R3_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  typedef struct packed {
    logic pc_we;
    logic pc_sel;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } ctrl_t;

  function automatic logic [4:0] op_of(input logic [15:0] ir);
    return ir[OP_HI:OP_LO];
  endfunction

  function automatic logic [2:0] r1_of(input logic [15:0] ir);
    return ir[R1_HI:R1_LO];
  endfunction

  function automatic logic [2:0] r2_of(input logic [15:0] ir);
    return ir[R2_HI:R2_LO];
  endfunction

  function automatic logic [2:0] r3_of(input logic [15:0] ir);
    return ir[R3_HI:R3_LO];
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: stall when EX holds a LOAD whose destination
// feeds a source of the ID instruction. Ports: id_ir, ex_ir in; stall out.
module hazard_detect
  import cpu_defs::*;
(
  input  logic [15:0] id_ir,
  input  logic [15:0] ex_ir,
  output logic        stall
);

  logic [4:0] id_op;
  logic       use_r1;
  logic       use_r2;
  logic       use_r3;
  logic       hit;
  logic       unused_bits;

  assign id_op = op_of(id_ir);

  always_comb begin
    use_r1 = 1'b0;
    use_r2 = 1'b0;
    use_r3 = 1'b0;
    unique case (id_op)
      OP_ADD, OP_SUB, OP_CMP, OP_AND,
      OP_OR, OP_XOR, OP_ADDC, OP_SUBC: begin
        use_r2 = 1'b1;
        use_r3 = 1'b1;
      end
      OP_LOAD, OP_SLL, OP_SRL,
      OP_SLA, OP_SRA: begin
        use_r2 = 1'b1;
      end
      OP_STORE: begin
        use_r1 = 1'b1;
        use_r2 = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_LDIH, OP_JMPR,
      OP_BZ, OP_BNZ, OP_BN, OP_BNN,
      OP_BC, OP_BNC: begin
        use_r1 = 1'b1;
      end
      default: begin
        use_r1 = 1'b0;
      end
    endcase
  end

  always_comb begin
    hit = 1'b0;
    if (use_r1 && r1_of(id_ir) == r1_of(ex_ir))
      hit = 1'b1;
    if (use_r2 && r2_of(id_ir) == r1_of(ex_ir))
      hit = 1'b1;
    if (use_r3 && r3_of(id_ir) == r1_of(ex_ir))
      hit = 1'b1;
  end

  assign stall = (op_of(ex_ir) == OP_LOAD) && hit;

  assign unused_bits = ^{id_ir[7], id_ir[3], ex_ir[7:0]};

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: run FSM, load-use stall, branch redirect/flush,
// debug counters. Ports: clock/reset/enable/start, id/ex/mem_ir, flag in;
// PC and pipeline-register enables/flushes, status, counters out.
module pipe_ctrl
  import cpu_defs::*;
#(
  parameter int CNT_W = 16,
  parameter int DRAIN = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [15:0]      id_ir,
  input  logic [15:0]      ex_ir,
  input  logic [15:0]      mem_ir,
  input  logic [2:0]       flag,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DW = (DRAIN < 2) ? 1 : $clog2(DRAIN + 1);
  localparam logic [DW-1:0] D_INIT = DW'(DRAIN);
  localparam logic [DW-1:0] D_ONE  = DW'(1);

  state_t     state;
  state_t     state_nx;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_nx;
  logic       stall;
  logic       taken;
  logic       halt_id;
  logic       active;
  logic       stall_evt;
  ctrl_t      ctrl;
  logic       unused_mem;

  logic nf;
  logic zf;
  logic cf;
  assign {nf, zf, cf} = flag;

  hazard_detect u_hazard (
    .id_ir (id_ir),
    .ex_ir (ex_ir),
    .stall (stall)
  );

  always_comb begin
    taken = 1'b0;
    unique case (op_of(mem_ir))
      OP_JUMP, OP_JMPR: taken = 1'b1;
      OP_BZ:   taken = zf;
      OP_BNZ:  taken = ~zf;
      OP_BN:   taken = nf;
      OP_BNN:  taken = ~nf;
      OP_BC:   taken = cf;
      OP_BNC:  taken = ~cf;
      default: taken = 1'b0;
    endcase
  end

  assign halt_id = (op_of(id_ir) == OP_HALT);
  assign active  = (state == ST_RUN) ||
                   (state == ST_DRAIN);
  // Branch outranks the stall, so a stall only counts without one.
  assign stall_evt = enable && (state == ST_RUN) &&
                     !taken && stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      dcnt      <= '0;
      cycle_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      dcnt  <= dcnt_nx;
      if (enable && active && ~&cycle_cnt)
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (stall_evt && ~&stall_cnt)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx = state;
    dcnt_nx  = dcnt;
    if (enable) begin
      unique case (state)
        ST_IDLE, ST_HALTED: begin
          if (start)
            state_nx = ST_RUN;
        end
        ST_RUN: begin
          if (!taken && !stall && halt_id) begin
            state_nx = ST_DRAIN;
            dcnt_nx  = D_INIT;
          end
        end
        ST_DRAIN: begin
          // A taken branch here means the HALT was fetched down
          // the wrong path, so resume normal fetch.
          if (taken) begin
            state_nx = ST_RUN;
            dcnt_nx  = '0;
          end else begin
            dcnt_nx = dcnt - D_ONE;
            if (dcnt == D_ONE)
              state_nx = ST_HALTED;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ctrl = '0;
    if (enable) begin
      unique case (state)
        ST_RUN: begin
          if (taken) begin
            ctrl = '1;
          end else if (stall) begin
            ctrl.id_ex_flush = 1'b1;
          end else if (halt_id) begin
            ctrl = '0;
          end else begin
            ctrl.pc_we    = 1'b1;
            ctrl.if_id_we = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (taken)
            ctrl = '1;
          else
            ctrl.id_ex_flush = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign pc_we        = ctrl.pc_we;
  assign pc_sel       = ctrl.pc_sel;
  assign if_id_we     = ctrl.if_id_we;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_flush = ctrl.ex_mem_flush;
  assign running      = active;
  assign halted       = (state == ST_HALTED);

  assign unused_mem = ^mem_ir[10:0];

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: behavioural model compared every
// cycle, plus directed literal checks from the test plan.
module tb_pipe_ctrl;

  localparam int CW  = 4;
  localparam int DR  = 3;
  localparam int MAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   id_ir = '0;
  logic [15:0]   ex_ir = '0;
  logic [15:0]   mem_ir = '0;
  logic [2:0]    flag = '0;
  logic          pc_we;
  logic          pc_sel;
  logic          if_id_we;
  logic          if_id_flush;
  logic          id_ex_flush;
  logic          ex_mem_flush;
  logic          running;
  logic          halted;
  logic [CW-1:0] cycle_cnt;
  logic [CW-1:0] stall_cnt;

  pipe_ctrl #(.CNT_W(CW), .DRAIN(DR)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .start        (start),
    .id_ir        (id_ir),
    .ex_ir        (ex_ir),
    .mem_ir       (mem_ir),
    .flag         (flag),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .if_id_we     (if_id_we),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .running      (running),
    .halted       (halted),
    .cycle_cnt    (cycle_cnt),
    .stall_cnt    (stall_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, req, $time);
    end
  endtask

  // Instruction builders
  function automatic logic [15:0] mk(input int op, input int a,
                                     input int b, input int c);
    logic [15:0] w;
    w = '0;
    w[15:11] = op[4:0];
    w[10:8]  = a[2:0];
    w[6:4]   = b[2:0];
    w[2:0]   = c[2:0];
    return w;
  endfunction

  // Model: does instruction ir read register r?
  function automatic bit reads(input logic [15:0] ir,
                               input logic [2:0] r);
    int op;
    bit u1, u2, u3;
    op = int'(ir[15:11]);
    u3 = op inside {8, 10, 12, 13, 14, 15, 17, 18};
    u2 = u3 || op inside {2, 3, 4, 5, 6, 7};
    u1 = op inside {3, 9, 11, 16, 25} || op >= 26;
    return (u1 && ir[10:8] == r) ||
           (u2 && ir[6:4] == r) ||
           (u3 && ir[2:0] == r);
  endfunction

  function automatic bit br_taken(input logic [15:0] ir,
                                  input logic [2:0] f);
    case (int'(ir[15:11]))
      24, 25:  return 1'b1;
      26:      return f[1];
      27:      return !f[1];
      28:      return f[2];
      29:      return !f[2];
      30:      return f[0];
      31:      return !f[0];
      default: return 1'b0;
    endcase
  endfunction

  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_HALT} mst_t;
  mst_t ms = M_IDLE;
  mst_t ms_n = M_IDLE;
  int   mb = 0, mb_n = 0;
  int   mcyc = 0, mcyc_n = 0;
  int   mstl = 0, mstl_n = 0;
  bit   armed = 1'b0;
  bit [5:0] e;
  bit   br, lu;

  // e = {pc_we,pc_sel,if_id_we,if_id_flush,id_ex_flush,ex_mem_flush}
  always @(negedge clock) begin
    e = '0;
    ms_n = ms;
    mb_n = mb;
    mcyc_n = mcyc;
    mstl_n = mstl;
    br = br_taken(mem_ir, flag);
    lu = (ex_ir[15:11] == 5'd2) && reads(id_ir, ex_ir[10:8]);
    if (enable) begin
      if (ms == M_RUN || ms == M_DRAIN)
        mcyc_n = (mcyc < MAX) ? mcyc + 1 : MAX;
      case (ms)
        M_IDLE, M_HALT: if (start) ms_n = M_RUN;
        M_RUN: begin
          if (br) e = 6'b111111;
          else if (lu) begin
            e = 6'b000010;
            mstl_n = (mstl < MAX) ? mstl + 1 : MAX;
          end else if (id_ir[15:11] == 5'd1) begin
            ms_n = M_DRAIN;
            mb_n = DR;
          end else e = 6'b101000;
        end
        M_DRAIN: begin
          if (br) begin
            e = 6'b111111;
            ms_n = M_RUN;
          end else begin
            e = 6'b000010;
            mb_n = mb - 1;
            if (mb_n == 0) ms_n = M_HALT;
          end
        end
        default: ;
      endcase
    end
    if (reset) begin
      ms_n = M_IDLE;
      mb_n = 0;
      mcyc_n = 0;
      mstl_n = 0;
    end
    if (armed) begin
      chk("ctrl", {26'd0, pc_we, pc_sel, if_id_we,
                   if_id_flush, id_ex_flush, ex_mem_flush},
          {26'd0, e});
      chk("running", {31'd0, running},
          {31'd0, (ms == M_RUN || ms == M_DRAIN)});
      chk("halted", {31'd0, halted}, {31'd0, (ms == M_HALT)});
      chk("cycle_cnt", 32'(cycle_cnt), mcyc);
      chk("stall_cnt", 32'(stall_cnt), mstl);
    end
  end

  always @(posedge clock) begin
    ms   <= ms_n;
    mb   <= mb_n;
    mcyc <= mcyc_n;
    mstl <= mstl_n;
    if (reset) armed <= 1'b1;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  logic [15:0] ADD312, LD1, LD4, LD5, ST5, BN1, JMP, BZ0, HLT;

  initial begin
    ADD312 = mk(8, 3, 1, 2);
    LD1    = mk(2, 1, 0, 0);
    LD4    = mk(2, 4, 0, 0);
    LD5    = mk(2, 5, 0, 0);
    ST5    = mk(3, 5, 0, 0);
    BN1    = mk(28, 1, 0, 0);
    JMP    = mk(24, 0, 0, 0);
    BZ0    = mk(26, 0, 0, 0);
    HLT    = mk(1, 0, 0, 0);

    cyc(2);
    reset = 1'b0;
    #1;
    chk("rst_running", {31'd0, running}, 0);
    chk("rst_pc_we", {31'd0, pc_we}, 0);
    chk("rst_cycle", 32'(cycle_cnt), 0);

    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(5);
    chk("nop_cycle5", 32'(cycle_cnt), 5);
    chk("nop_pc_we", {31'd0, pc_we}, 1);
    chk("nop_running", {31'd0, running}, 1);

    id_ir = ADD312;
    ex_ir = LD1;
    #1;
    chk("lu_pc_we", {31'd0, pc_we}, 0);
    chk("lu_if_id_we", {31'd0, if_id_we}, 0);
    chk("lu_flush", {31'd0, id_ex_flush}, 1);
    cyc(1);
    ex_ir = '0;
    #1;
    chk("lu_stall1", 32'(stall_cnt), 1);
    chk("lu_after", {31'd0, pc_we}, 1);
    ex_ir = LD4;
    #1;
    chk("lu_nomatch", {31'd0, pc_we}, 1);
    id_ir = ST5;
    ex_ir = LD5;
    #1;
    chk("lu_store_r1", {31'd0, id_ex_flush}, 1);
    cyc(1);
    id_ir = '0;
    ex_ir = '0;

    mem_ir = BN1;
    flag = 3'b100;
    #1;
    chk("bn_sel", {31'd0, pc_sel}, 1);
    chk("bn_flush", {29'd0, if_id_flush, id_ex_flush,
                     ex_mem_flush}, 3'b111);
    flag = 3'b000;
    #1;
    chk("bn_nt_sel", {31'd0, pc_sel}, 0);
    chk("bn_nt_flush", {29'd0, if_id_flush, id_ex_flush,
                        ex_mem_flush}, 0);
    cyc(1);
    id_ir = ADD312;
    ex_ir = LD1;
    mem_ir = JMP;
    #1;
    chk("br_over_lu", {31'd0, pc_we}, 1);
    cyc(1);
    chk("br_no_stall", 32'(stall_cnt), 2);
    id_ir = '0;
    ex_ir = '0;
    mem_ir = '0;

    id_ir = HLT;
    #1;
    chk("halt_pc_we", {31'd0, pc_we}, 0);
    chk("halt_id_ex", {31'd0, id_ex_flush}, 0);
    cyc(1);
    for (int i = 0; i < DR; i++) begin
      chk("drain_flush", {31'd0, id_ex_flush}, 1);
      chk("drain_halted", {31'd0, halted}, 0);
      cyc(1);
    end
    chk("halted", {31'd0, halted}, 1);
    chk("halted_we", {29'd0, pc_we, if_id_we, running}, 0);
    cyc(2);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    id_ir = '0;
    #1;
    chk("restart", {31'd0, pc_we}, 1);

    id_ir = HLT;
    mem_ir = JMP;
    #1;
    chk("halt_jmp_sel", {31'd0, pc_sel}, 1);
    cyc(1);
    id_ir = '0;
    mem_ir = '0;
    #1;
    chk("halt_jmp_run", {31'd0, pc_we}, 1);

    id_ir = HLT;
    cyc(2);
    mem_ir = BZ0;
    flag = 3'b010;
    #1;
    chk("drain_bz_sel", {31'd0, pc_sel}, 1);
    cyc(1);
    id_ir = '0;
    mem_ir = '0;
    flag = '0;
    #1;
    chk("drain_bz_run", {31'd0, pc_we}, 1);
    chk("drain_bz_nohalt", {31'd0, halted}, 0);

    enable = 1'b0;
    #1;
    chk("dis_we", {31'd0, pc_we}, 0);
    cyc(4);
    chk("dis_we4", {30'd0, pc_we, if_id_we}, 0);
    enable = 1'b1;
    cyc(2);

    id_ir = HLT;
    cyc(1);
    id_ir = '0;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    #1;
    chk("rst_drain_run", {31'd0, running}, 0);
    chk("rst_drain_cyc", 32'(cycle_cnt), 0);
    chk("rst_drain_stl", 32'(stall_cnt), 0);

    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(20);
    chk("cyc_sat", 32'(cycle_cnt), MAX);
    cyc(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
